// File: rtl/serdes_frame_sequencer.sv
// Frame sequencer for a serializer/deserializer pair: load, WIDTH shifts, capture,
// then a valid/ready delivery and an inter-frame gap.
module serdes_frame_sequencer #(
  parameter  int WIDTH      = 4,
  parameter  int GAP_CYCLES = 1,
  localparam int CW         = $clog2(WIDTH)
) (
  input  logic          input_clock2_slow_clk_2,
  input  logic          input_push_button1_reset_1,
  input  logic          tx_valid,
  output logic          tx_ready,
  input  logic          pause,
  output logic          load,
  output logic          shift_en,
  output logic [CW-1:0] bit_cnt,
  output logic          capture,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          busy,
  output logic [7:0]    frame_cnt,
  output logic [2:0]    state
);

  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4,
    GAP     = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
  logic [7:0]      frame_cnt_reg, frame_cnt_next;

  always_ff @(posedge input_clock2_slow_clk_2 or posedge input_push_button1_reset_1) begin
    if (input_push_button1_reset_1) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    frame_cnt_next = frame_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (tx_valid) state_next = LOAD;
      end
      LOAD: begin
        bit_cnt_next = '0;
        state_next   = SHIFT;
      end
      SHIFT: begin
        // pause freezes both the bit index and the state
        if (!pause) begin
          if (bit_cnt_reg == CW'(WIDTH - 1)) begin
            bit_cnt_next = '0;
            state_next   = CAPTURE;
          end else begin
            bit_cnt_next = bit_cnt_reg + CW'(1);
          end
        end
      end
      CAPTURE: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (rx_ready) begin
          frame_cnt_next = frame_cnt_reg + 8'd1;
          gap_cnt_next   = '0;
          state_next     = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_reg == GW'(GAP_LAST)) begin
          gap_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + GW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // tx_ready is the only output that must drop combinationally with reset
  assign tx_ready  = (state_reg == IDLE) & ~input_push_button1_reset_1;
  assign shift_en  = (state_reg == SHIFT) & ~pause;
  assign load      = (state_reg == LOAD);
  assign capture   = (state_reg == CAPTURE);
  assign rx_valid  = (state_reg == HOLD);
  assign busy      = (state_reg != IDLE);
  assign bit_cnt   = bit_cnt_reg;
  assign frame_cnt = frame_cnt_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_serdes_frame_sequencer.sv
// Directed bench for serdes_frame_sequencer: cycle-by-cycle expected outputs per frame,
// plus a long back-to-back run on default and zero-gap instances.
module tb_serdes_frame_sequencer;

  logic       clk;
  logic       rst;
  logic       tx_valid;
  logic       pause;
  logic       rx_ready;

  logic       tx_ready, load, shift_en, capture, rx_valid, busy;
  logic [1:0] bit_cnt;
  logic [7:0] frame_cnt;
  logic [2:0] state;

  logic       tx_ready_z, load_z, shift_en_z, capture_z, rx_valid_z, busy_z;
  logic [1:0] bit_cnt_z;
  logic [7:0] frame_cnt_z;
  logic [2:0] state_z;

  int n_cmp = 0;
  int n_err = 0;

  serdes_frame_sequencer #(.WIDTH(4), .GAP_CYCLES(1)) dut (
    .input_clock2_slow_clk_2    (clk),
    .input_push_button1_reset_1 (rst),
    .tx_valid                   (tx_valid),
    .tx_ready                   (tx_ready),
    .pause                      (pause),
    .load                       (load),
    .shift_en                   (shift_en),
    .bit_cnt                    (bit_cnt),
    .capture                    (capture),
    .rx_valid                   (rx_valid),
    .rx_ready                   (rx_ready),
    .busy                       (busy),
    .frame_cnt                  (frame_cnt),
    .state                      (state)
  );

  serdes_frame_sequencer #(.WIDTH(4), .GAP_CYCLES(0)) dut_nogap (
    .input_clock2_slow_clk_2    (clk),
    .input_push_button1_reset_1 (rst),
    .tx_valid                   (tx_valid),
    .tx_ready                   (tx_ready_z),
    .pause                      (pause),
    .load                       (load_z),
    .shift_en                   (shift_en_z),
    .bit_cnt                    (bit_cnt_z),
    .capture                    (capture_z),
    .rx_valid                   (rx_valid_z),
    .rx_ready                   (rx_ready),
    .busy                       (busy_z),
    .frame_cnt                  (frame_cnt_z),
    .state                      (state_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, check the cycle's outputs, advance to the next cycle.
  // eo = {tx_ready, load, shift_en, capture, rx_valid, busy}
  task automatic step(input logic r, input logic tv, input logic p, input logic rr,
                      input logic [5:0] eo, input int es, input int eb, input int efc,
                      input string tag);
    rst = r; tx_valid = tv; pause = p; rx_ready = rr;
    #1;
    $display("%s: state=%0d outs=%b bit_cnt=%0d frame_cnt=%0d", tag, state,
             {tx_ready, load, shift_en, capture, rx_valid, busy}, bit_cnt, frame_cnt);
    check_val({tag, ".outs"}, 32'({tx_ready, load, shift_en, capture, rx_valid, busy}), 32'(eo));
    check_val({tag, ".state"}, 32'(state), es);
    check_val({tag, ".bit_cnt"}, 32'(bit_cnt), eb);
    check_val({tag, ".frame_cnt"}, 32'(frame_cnt), efc);
    @(negedge clk);
  endtask

  int last_ld, last_ld_z, n_ld, n_ld_z;

  initial begin
    rst = 1'b1; tx_valid = 1'b0; pause = 1'b0; rx_ready = 1'b0;
    @(negedge clk);

    // reset held, then released with tx_valid low
    step(1, 0, 0, 0, 6'b000000, 0, 0, 0, "rst_a");
    step(1, 0, 0, 0, 6'b000000, 0, 0, 0, "rst_b");
    step(0, 0, 0, 0, 6'b100000, 0, 0, 0, "rel");

    // one frame, defaults, rx_ready high
    step(0, 1, 0, 1, 6'b100000, 0, 0, 0, "f1_c0");
    step(0, 0, 0, 1, 6'b010001, 1, 0, 0, "f1_c1");
    step(0, 0, 0, 1, 6'b001001, 2, 0, 0, "f1_c2");
    step(0, 0, 0, 1, 6'b001001, 2, 1, 0, "f1_c3");
    step(0, 0, 0, 1, 6'b001001, 2, 2, 0, "f1_c4");
    step(0, 0, 0, 1, 6'b001001, 2, 3, 0, "f1_c5");
    step(0, 0, 0, 1, 6'b000101, 3, 0, 0, "f1_c6");
    step(0, 0, 0, 1, 6'b000011, 4, 0, 0, "f1_c7");
    step(0, 0, 0, 1, 6'b000001, 5, 0, 1, "f1_c8");
    step(0, 0, 0, 1, 6'b100000, 0, 0, 1, "f1_c9");

    // pause for three cycles while bit_cnt=2
    step(0, 1, 0, 1, 6'b100000, 0, 0, 1, "f2_c0");
    step(0, 0, 0, 1, 6'b010001, 1, 0, 1, "f2_c1");
    step(0, 0, 0, 1, 6'b001001, 2, 0, 1, "f2_c2");
    step(0, 0, 0, 1, 6'b001001, 2, 1, 1, "f2_c3");
    step(0, 0, 1, 1, 6'b000001, 2, 2, 1, "f2_c4");
    step(0, 0, 1, 1, 6'b000001, 2, 2, 1, "f2_c5");
    step(0, 0, 1, 1, 6'b000001, 2, 2, 1, "f2_c6");
    step(0, 0, 0, 1, 6'b001001, 2, 2, 1, "f2_c7");
    step(0, 0, 0, 1, 6'b001001, 2, 3, 1, "f2_c8");
    step(0, 0, 0, 1, 6'b000101, 3, 0, 1, "f2_c9");
    step(0, 0, 0, 1, 6'b000011, 4, 0, 1, "f2_c10");
    step(0, 0, 0, 1, 6'b000001, 5, 0, 2, "f2_c11");
    step(0, 0, 0, 1, 6'b100000, 0, 0, 2, "f2_c12");

    // rx_ready low for 5 HOLD cycles; tx_valid during HOLD/GAP must not queue
    step(0, 1, 0, 0, 6'b100000, 0, 0, 2, "f3_c0");
    step(0, 0, 0, 0, 6'b010001, 1, 0, 2, "f3_c1");
    step(0, 0, 0, 0, 6'b001001, 2, 0, 2, "f3_c2");
    step(0, 0, 0, 0, 6'b001001, 2, 1, 2, "f3_c3");
    step(0, 0, 0, 0, 6'b001001, 2, 2, 2, "f3_c4");
    step(0, 0, 0, 0, 6'b001001, 2, 3, 2, "f3_c5");
    step(0, 0, 0, 0, 6'b000101, 3, 0, 2, "f3_c6");
    step(0, 0, 0, 0, 6'b000011, 4, 0, 2, "f3_c7");
    for (int c = 8; c < 12; c++)
      step(0, 1, 0, 0, 6'b000011, 4, 0, 2, $sformatf("f3_c%0d", c));
    step(0, 1, 0, 1, 6'b000011, 4, 0, 2, "f3_c12");
    step(0, 1, 0, 1, 6'b000001, 5, 0, 3, "f3_c13");
    step(0, 0, 0, 1, 6'b100000, 0, 0, 3, "f3_c14");
    step(0, 0, 0, 1, 6'b100000, 0, 0, 3, "f3_c15");

    // reset pulsed at cycle 4 of a frame
    step(0, 1, 0, 1, 6'b100000, 0, 0, 3, "f4_c0");
    step(0, 0, 0, 1, 6'b010001, 1, 0, 3, "f4_c1");
    step(0, 0, 0, 1, 6'b001001, 2, 0, 3, "f4_c2");
    step(0, 0, 0, 1, 6'b001001, 2, 1, 3, "f4_c3");
    #1;
    check_val("f4_c4.shift_en", 32'(shift_en), 1);
    step(1, 0, 0, 1, 6'b000000, 0, 0, 0, "f4_rst0");
    step(1, 0, 0, 1, 6'b000000, 0, 0, 0, "f4_rst1");
    step(0, 1, 0, 1, 6'b100000, 0, 0, 0, "f5_c0");
    step(0, 0, 0, 1, 6'b010001, 1, 0, 0, "f5_c1");
    step(0, 0, 0, 1, 6'b001001, 2, 0, 0, "f5_c2");
    step(0, 0, 0, 1, 6'b001001, 2, 1, 0, "f5_c3");
    step(0, 0, 0, 1, 6'b001001, 2, 2, 0, "f5_c4");
    step(0, 0, 0, 1, 6'b001001, 2, 3, 0, "f5_c5");
    step(0, 0, 0, 1, 6'b000101, 3, 0, 0, "f5_c6");
    step(0, 0, 0, 1, 6'b000011, 4, 0, 0, "f5_c7");
    step(0, 0, 0, 1, 6'b000001, 5, 0, 1, "f5_c8");
    step(0, 0, 0, 1, 6'b100000, 0, 0, 1, "f5_c9");

    // back-to-back frames from a clean reset: period 9 (gap 1) and 8 (gap 0)
    step(1, 0, 0, 1, 6'b000000, 0, 0, 0, "b2b_rst");
    rst = 1'b0; tx_valid = 1'b1; pause = 1'b0; rx_ready = 1'b1;
    last_ld = -1; last_ld_z = -1; n_ld = 0; n_ld_z = 0;
    for (int c = 0; c < 2304; c++) begin
      #1;
      if (load) begin
        if (last_ld >= 0) check_val("b2b_period_gap1", c - last_ld, 9);
        last_ld = c;
        n_ld++;
        $display("gap1 frame %0d accepted at cycle %0d frame_cnt=%0d", n_ld, c - 1, frame_cnt);
      end
      if (load_z) begin
        if (last_ld_z >= 0) check_val("b2b_period_gap0", c - last_ld_z, 8);
        last_ld_z = c;
        n_ld_z++;
        $display("gap0 frame %0d accepted at cycle %0d frame_cnt=%0d", n_ld_z, c - 1, frame_cnt_z);
      end
      if (c == 2047) check_val("gap0_fc_255", 32'(frame_cnt_z), 255);
      if (c == 2048) check_val("gap0_fc_wrap", 32'(frame_cnt_z), 0);
      if (c == 2294) check_val("gap1_fc_255", 32'(frame_cnt), 255);
      if (c == 2303) check_val("gap1_fc_wrap", 32'(frame_cnt), 0);
      @(negedge clk);
    end
    check_val("gap1_loads", n_ld, 256);
    check_val("gap0_loads", n_ld_z, 288);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serdes_frame_sequencer.md
# serdes_frame_sequencer

Single-clock controller that sequences one serializer → deserializer transfer per frame: parallel load, WIDTH shift enables, then deserializer capture. Delivers the captured frame with a valid/ready handshake and inserts an inter-frame gap. Sits between the word source and the shift-register pair. It owns their load/shift/capture controls and replaces the free-running ripple counter as the frame timebase.

## Interface
- WIDTH, 4: bits per frame; integer ≥ 2.
- GAP_CYCLES, 1: idle cycles after each delivered frame; integer ≥ 0.
- CW, $clog2(WIDTH): width of bit_cnt; derived, not overridden.

Ports:
- input_clock2_slow_clk_2  in  1  clock; all state changes on its rising edge.
- input_push_button1_reset_1  in  1  asynchronous, active-high reset.
- tx_valid  in  1  source has a word ready to load.
- tx_ready  out  1  controller accepts a word this cycle.
- pause  in  1  stalls shifting while high; honoured only in SHIFT.
- load  out  1  one-cycle parallel-load strobe to the serializer.
- shift_en  out  1  shift enable, common to serializer and deserializer.
- bit_cnt  out  CW  index of the bit currently being shifted.
- capture  out  1  one-cycle strobe latching deserializer contents.
- rx_valid  out  1  captured frame available to the sink.
- rx_ready  in  1  sink accepts the frame.
- busy  out  1  high in every state except IDLE.
- frame_cnt  out  8  count of delivered frames; wraps 255 → 0.
- state  out  3  state encoding for debug: IDLE=0, LOAD=1, SHIFT=2, CAPTURE=3, HOLD=4, GAP=5.

## Operation
- Outputs are Moore outputs, decoded from registered state, except:
  - tx_ready = (state==IDLE) & ~reset.
  - shift_en = (state==SHIFT) & ~pause.
- Reset, asynchronous and immediate: state=IDLE, bit_cnt=0, gap counter=0, frame_cnt=0. All outputs are 0 while reset is high, including tx_ready. After release: tx_ready=1, all other outputs 0.
- IDLE: tx_ready=1. If tx_valid is sampled high, go to LOAD; otherwise stay.
- LOAD: load=1 for exactly one cycle, bit_cnt=0, then go to SHIFT.
- SHIFT: bit_cnt increments only on cycles where shift_en=1.
  - Leave for CAPTURE on the edge where shift_en=1 and bit_cnt==WIDTH-1; bit_cnt returns to 0 on that edge.
  - pause freezes bit_cnt and keeps the state; pause may be held for any length of time.
- CAPTURE: capture=1 for one cycle, then go to HOLD. rx_ready is ignored here.
- HOLD: rx_valid=1, held until rx_ready is sampled high.
  - On that edge: frame_cnt += 1 (mod 256).
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP: counts GAP_CYCLES cycles, then goes to IDLE. tx_valid is ignored during GAP.
- Exactly WIDTH shift_en pulses occur between each load and its capture, regardless of pause.
- tx_valid in any state other than IDLE has no effect; there is no queuing.

## Timing
- Cycle numbering: cycle 0 is the acceptance cycle (IDLE with tx_valid=1). Figures below assume no pause and rx_ready=1.
- Cycle 1: load=1.
- Cycles 2 … WIDTH+1: shift_en=1, with bit_cnt = 0 … WIDTH-1.
- Cycle WIDTH+2: capture=1.
- Cycle WIDTH+3: rx_valid=1; frame_cnt updates at the end of this cycle.
- GAP_CYCLES cycles follow, then IDLE.
- Minimum frame period is WIDTH+4+GAP_CYCLES cycles. Defaults give 9.
- Each pause cycle in SHIFT adds exactly one cycle. Each cycle rx_ready stays low in HOLD adds exactly one cycle.
- Reset asserted mid-frame:
  - The frame is abandoned and no capture is emitted.
  - frame_cnt clears.
  - tx_ready rises in the first cycle after reset deasserts.

## Test plan
- Reset release, tx_valid=0: tx_ready=1; busy=0; load, shift_en, capture and rx_valid all 0; frame_cnt=0; state=0.
- One frame, defaults, rx_ready=1:
  - tx_valid at cycle 0 → load at cycle 1; shift_en at cycles 2–5 with bit_cnt 0,1,2,3.
  - capture at 6, rx_valid at 7, frame_cnt=1 from cycle 8, tx_ready=1 at cycle 9.
- pause high for 3 cycles while bit_cnt=2 → shift_en low for those 3 cycles, bit_cnt holds at 2, capture arrives at cycle 9. Exactly 4 shift_en pulses total.
- rx_ready held low 5 cycles in HOLD → rx_valid stays high for 6 cycles, frame_cnt increments once, tx_ready stays low until HOLD and GAP complete.
- tx_valid held high continuously for 256 frames → acceptances every 9 cycles, frame_cnt wraps to 0. With GAP_CYCLES=0 the period is 8 cycles.
- Reset pulsed at cycle 4 of a frame → all outputs 0 immediately, no capture pulse, frame_cnt=0. A new frame is accepted the cycle after release.
